// File: rtl/sd_spi_cmd_pkg.sv
// sd_pkg: shared definitions for the SD-card SPI command path.
// Holds the command-engine state enum, the SD command indices used by
// the init/read sequencers, and the fixed CRC bytes used when the CRC7
// generator is not built in.
package sd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SEND,
    ST_POLL,
    ST_EXT,
    ST_TRAIL,
    ST_DONE
  } sd_cmd_state_t;

  localparam logic [5:0] SD_CMD0   = 6'd0;
  localparam logic [5:0] SD_CMD8   = 6'd8;
  localparam logic [5:0] SD_CMD17  = 6'd17;
  localparam logic [5:0] SD_CMD55  = 6'd55;
  localparam logic [5:0] SD_ACMD41 = 6'd41;
  localparam logic [5:0] SD_CMD58  = 6'd58;

  localparam logic [7:0] SD_CRC_CMD0 = 8'h95;
  localparam logic [7:0] SD_CRC_CMD8 = 8'h87;
  localparam logic [7:0] SD_FILL     = 8'hFF;

  // The card checks CRC only on CMD0 and CMD8 in SPI mode, so a dummy
  // byte with the end bit set is enough for every other command.
  function automatic logic [7:0] sd_fixed_crc(input logic [5:0] idx);
    logic [7:0] b;
    b = 8'h01;
    if (idx == SD_CMD0) b = SD_CRC_CMD0;
    if (idx == SD_CMD8) b = SD_CRC_CMD8;
    return b;
  endfunction

endpackage

// File: rtl/sd_spi_cmd_if.sv
// sd_spi_cmd_if: command handshake between a sequencer and sd_spi_cmd.
// master: start, cmd_idx[5:0], cmd_arg[31:0], resp_len[2:0] out;
//         busy, done, timeout, r1[7:0], resp_ext[31:0] in.
// slave : the same signals with directions reversed.
interface sd_spi_cmd_if;
  logic        start;
  logic [5:0]  cmd_idx;
  logic [31:0] cmd_arg;
  logic [2:0]  resp_len;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [7:0]  r1;
  logic [31:0] resp_ext;

  modport master (
    output start, cmd_idx, cmd_arg, resp_len,
    input  busy, done, timeout, r1, resp_ext
  );

  modport slave (
    input  start, cmd_idx, cmd_arg, resp_len,
    output busy, done, timeout, r1, resp_ext
  );
endinterface

// File: rtl/sd_spi_cmd_crc7.sv
// sd_crc7: bytewise CRC7 (x^7 + x^3 + 1, initial value 0) for SD frames.
// Ports: CLK, reset (sync, active-high), clear (restart accumulator),
//        byte_valid (fold data into accumulator), data[7:0], crc[6:0].
module sd_crc7 (
  input  logic       CLK,
  input  logic       reset,
  input  logic       clear,
  input  logic       byte_valid,
  input  logic [7:0] data,
  output logic [6:0] crc
);

  logic [6:0] r_crc;
  logic [6:0] w_next;

  // Fold all eight bits of the byte into the CRC in one cycle, MSB first.
  always_comb begin
    w_next = r_crc;
    for (int i = 7; i >= 0; i--) begin
      if (w_next[6] ^ data[i]) w_next = {w_next[5:0], 1'b0} ^ 7'h09;
      else                     w_next = {w_next[5:0], 1'b0};
    end
  end

  always_ff @(posedge CLK) begin
    if (reset || clear) r_crc <= '0;
    else if (byte_valid) r_crc <= w_next;
  end

  assign crc = r_crc;

endmodule

// File: rtl/sd_spi_cmd.sv
// sd_spi_cmd: SPI-mode SD command engine. Frames a 48-bit command, shifts it
// out (mode 0, MSB first), polls for R1 and optionally collects up to four
// trailing response bytes.
// Ports: CLK, reset (sync, active-high), cmd (sd_spi_cmd_if.slave handshake),
//        spi_sclk/spi_cs_n/spi_mosi to the card, spi_miso from the card.
// Params: CLK_DIV (CLK cycles per SCLK half-period), NCR_MAX (R1 poll limit).
// Build option: define SD_SPI_CRC7_EN to compute B5 with the sd_crc7
// generator; otherwise B5 comes from the fixed CMD0/CMD8 table.
module sd_spi_cmd
  import sd_pkg::*;
#(
  parameter int CLK_DIV = 125,
  parameter int NCR_MAX = 8
) (
  input  logic         CLK,
  input  logic         reset,
  sd_spi_cmd_if.slave  cmd,
  output logic         spi_sclk,
  output logic         spi_cs_n,
  output logic         spi_mosi,
  input  logic         spi_miso
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  sd_cmd_state_t r_state, w_nextState;
  logic [DIV_W-1:0] r_div;
  logic        r_sclk, r_active, r_csN, r_timeout, r_done;
  logic [2:0]  r_bitCnt, r_extLen;
  logic [7:0]  r_txSr, r_rxSr, r_cnt, r_r1;
  logic [5:0]  r_idx;
  logic [31:0] r_arg, r_respExt;

  logic w_tick, w_rise, w_fall, w_byteEnd;
  logic w_accept, w_load, w_loadFrame, w_stop, w_csOff;
  logic w_cntClr, w_cntInc, w_capR1, w_setTimeout, w_capExt;
  logic [2:0] w_frameSel;
  logic [7:0] w_frameByte, w_crcByte;

  // SCLK toggles each time the divider wraps; a byte ends on its 8th fall.
  assign w_tick    = r_active && (r_div == DIV_W'(CLK_DIV - 1));
  assign w_rise    = w_tick && !r_sclk;
  assign w_fall    = w_tick && r_sclk;
  assign w_byteEnd = w_fall && (r_bitCnt == 3'd7);

  // Frame byte to load next: B0 at the end of SETUP, then B(cnt+1) in SEND.
  assign w_frameSel = (r_state == ST_SETUP) ? 3'd0 : (r_cnt[2:0] + 3'd1);

  always_comb begin
    w_frameByte = w_crcByte;
    case (w_frameSel)
      3'd0:    w_frameByte = {2'b01, r_idx};
      3'd1:    w_frameByte = r_arg[31:24];
      3'd2:    w_frameByte = r_arg[23:16];
      3'd3:    w_frameByte = r_arg[15:8];
      3'd4:    w_frameByte = r_arg[7:0];
      default: w_frameByte = w_crcByte;
    endcase
  end

`ifdef SD_SPI_CRC7_EN
  logic [6:0] w_crc7;
  logic       w_crcValid;

  // B0..B4 are folded in as they are loaded, so the CRC is ready for B5.
  assign w_crcValid = w_loadFrame && (w_frameSel != 3'd5);

  sd_crc7 u_crc7 (
    .CLK        (CLK),
    .reset      (reset),
    .clear      (w_accept),
    .byte_valid (w_crcValid),
    .data       (w_frameByte),
    .crc        (w_crc7)
  );

  assign w_crcByte = {w_crc7, 1'b1};
`else
  assign w_crcByte = sd_fixed_crc(r_idx);
`endif

  always_ff @(posedge CLK) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_nextState;
  end

  // Sequencing happens only at byte boundaries; the strobes below tell the
  // datapath what to load into the shifter for the following byte.
  always_comb begin
    w_nextState  = r_state;
    w_accept     = 1'b0;
    w_load       = 1'b0;
    w_loadFrame  = 1'b0;
    w_stop       = 1'b0;
    w_csOff      = 1'b0;
    w_cntClr     = 1'b0;
    w_cntInc     = 1'b0;
    w_capR1      = 1'b0;
    w_setTimeout = 1'b0;
    w_capExt     = 1'b0;
    case (r_state)
      ST_IDLE: if (cmd.start) begin
        w_accept    = 1'b1;
        w_nextState = ST_SETUP;
      end
      ST_SETUP: if (w_byteEnd) begin
        w_loadFrame = 1'b1;
        w_cntClr    = 1'b1;
        w_nextState = ST_SEND;
      end
      ST_SEND: if (w_byteEnd) begin
        if (r_cnt == 8'd5) begin
          w_load      = 1'b1;
          w_cntClr    = 1'b1;
          w_nextState = ST_POLL;
        end else begin
          w_loadFrame = 1'b1;
          w_cntInc    = 1'b1;
        end
      end
      ST_POLL: if (w_byteEnd) begin
        w_load = 1'b1;
        if (!r_rxSr[7]) begin
          w_capR1     = 1'b1;
          w_cntClr    = 1'b1;
          w_nextState = (r_extLen != 3'd0) ? ST_EXT : ST_TRAIL;
        end else if (r_cnt == 8'(NCR_MAX - 1)) begin
          w_setTimeout = 1'b1;
          w_nextState  = ST_TRAIL;
        end else begin
          w_cntInc = 1'b1;
        end
      end
      ST_EXT: if (w_byteEnd) begin
        w_load   = 1'b1;
        w_capExt = 1'b1;
        if (r_cnt == {5'd0, r_extLen - 3'd1}) w_nextState = ST_TRAIL;
        else                                  w_cntInc    = 1'b1;
      end
      // The shifter stops on the trailing byte's last fall; CS_N is
      // released one CLK later.
      ST_TRAIL: begin
        if (w_byteEnd) begin
          w_stop = 1'b1;
        end else if (!r_active) begin
          w_csOff     = 1'b1;
          w_nextState = ST_DONE;
        end
      end
      ST_DONE: w_nextState = ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Shifter, divider and response registers. MOSI is the top bit of the
  // transmit shift register, so it only moves on SCLK falls or a reload.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_div     <= '0;
      r_sclk    <= 1'b0;
      r_bitCnt  <= '0;
      r_txSr    <= SD_FILL;
      r_rxSr    <= SD_FILL;
      r_active  <= 1'b0;
      r_csN     <= 1'b1;
      r_idx     <= '0;
      r_arg     <= '0;
      r_extLen  <= '0;
      r_cnt     <= '0;
      r_r1      <= SD_FILL;
      r_respExt <= '0;
      r_timeout <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= (r_state == ST_DONE);
      if (w_accept) begin
        r_idx     <= cmd.cmd_idx;
        r_arg     <= cmd.cmd_arg;
        r_extLen  <= (cmd.resp_len > 3'd4) ? 3'd4 : cmd.resp_len;
        r_r1      <= SD_FILL;
        r_respExt <= '0;
        r_timeout <= 1'b0;
        r_csN     <= 1'b0;
        r_active  <= 1'b1;
        r_div     <= '0;
        r_sclk    <= 1'b0;
        r_bitCnt  <= '0;
        r_txSr    <= SD_FILL;
        r_cnt     <= '0;
      end else begin
        if (r_active) r_div <= w_tick ? '0 : r_div + DIV_W'(1);
        if (w_tick) r_sclk <= ~r_sclk;
        if (w_rise) r_rxSr <= {r_rxSr[6:0], spi_miso};
        if (w_fall) begin
          r_bitCnt <= r_bitCnt + 3'd1;
          r_txSr   <= {r_txSr[6:0], 1'b1};
        end
        if (w_load)      r_txSr <= SD_FILL;
        if (w_loadFrame) r_txSr <= w_frameByte;
        if (w_stop) begin
          r_active <= 1'b0;
          r_txSr   <= SD_FILL;
        end
        if (w_csOff) r_csN <= 1'b1;
        if (w_cntClr)      r_cnt <= '0;
        else if (w_cntInc) r_cnt <= r_cnt + 8'd1;
        if (w_capR1) r_r1 <= r_rxSr;
        if (w_setTimeout) begin
          r_r1      <= SD_FILL;
          r_timeout <= 1'b1;
        end
        // First extra byte lands in the MSBs; unused low bytes stay zero.
        if (w_capExt) begin
          case (r_cnt[1:0])
            2'd0: r_respExt[31:24] <= r_rxSr;
            2'd1: r_respExt[23:16] <= r_rxSr;
            2'd2: r_respExt[15:8]  <= r_rxSr;
            default: r_respExt[7:0] <= r_rxSr;
          endcase
        end
      end
    end
  end

  assign cmd.busy     = (r_state != ST_IDLE);
  assign cmd.done     = r_done;
  assign cmd.timeout  = r_timeout;
  assign cmd.r1       = r_r1;
  assign cmd.resp_ext = r_respExt;
  assign spi_sclk     = r_sclk;
  assign spi_cs_n     = r_csN;
  assign spi_mosi     = r_txSr[7];

endmodule
